// File: rtl/spi_shift_engine_pkg.sv
// Shared constants and types for the SPI shift engine.
// SPI_MAX_CHAR is the largest transfer in bits. SPI_CHAR_LEN_BITS is the
// width of the length field that selects it. A length of 0 encodes
// SPI_MAX_CHAR bits.
package spi_shift_engine_pkg;

  localparam int unsigned SPI_MAX_CHAR      = 128;
  localparam int unsigned SPI_CHAR_LEN_BITS = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Serial shift engine for the SPI master.
// It launches tx_data on mosi and captures miso into rx_data. Timing comes
// from the clock generator's pos_edge/neg_edge strobes.
//
// Ports:
//   clk_in, rst            clock, asynchronous active-high reset
//   go                     start pulse, honoured only while idle
//   len                    bits per transfer; 0 selects MAX_CHAR
//   lsb                    1 = LSB first, 0 = MSB first
//   tx_negedge/rx_negedge  select the strobe used to launch / capture
//   pos_edge/neg_edge      one-cycle strobes from the clock generator
//   tx_data                parallel word, captured at go
//   miso                   serial input
//   tip                    transfer in progress (generator enable)
//   last                   all bits launched (generator last_clk)
//   mosi                   serial output
//   rx_data                parallel receive word
//   done                   one-cycle pulse at transfer completion
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int unsigned MAX_CHAR = SPI_MAX_CHAR,
  parameter int unsigned LEN_W    = SPI_CHAR_LEN_BITS
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                go,
  input  logic [LEN_W-1:0]    len,
  input  logic                lsb,
  input  logic                tx_negedge,
  input  logic                rx_negedge,
  input  logic                pos_edge,
  input  logic                neg_edge,
  input  logic [MAX_CHAR-1:0] tx_data,
  input  logic                miso,
  output logic                tip,
  output logic                last,
  output logic                mosi,
  output logic [MAX_CHAR-1:0] rx_data,
  output logic                done
);

  // One extra bit so a count of MAX_CHAR is representable.
  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned IDX_W = LEN_W;

  shift_state_e         state_q, state_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic                 lsb_q, lsb_d;
  logic                 tx_neg_q, tx_neg_d;
  logic                 rx_neg_q, rx_neg_d;
  logic [MAX_CHAR-1:0]  shadow_q, shadow_d;
  logic                 mosi_q, mosi_d;
  logic [MAX_CHAR-1:0]  rx_data_q, rx_data_d;
  logic                 done_q, done_d;

  logic [CNT_W-1:0]     n_dec_c;
  logic [IDX_W-1:0]     first_idx_c;
  logic [IDX_W-1:0]     tx_idx_c;
  logic [IDX_W-1:0]     rx_idx_c;
  logic                 tx_edge_c;
  logic                 rx_edge_c;
  logic                 rx_final_c;

  // Bit count decode, edge selection and bit indices.
  always_comb begin
    n_dec_c     = (len == '0) ? CNT_W'(MAX_CHAR) : CNT_W'(len);
    first_idx_c = lsb ? '0 : IDX_W'(n_dec_c - CNT_W'(1));
    tx_edge_c   = tx_neg_q ? neg_edge : pos_edge;
    rx_edge_c   = rx_neg_q ? neg_edge : pos_edge;
    // tx_cnt counts bits still to launch, so the next index counts from it.
    tx_idx_c    = lsb_q ? IDX_W'(n_q - tx_cnt_q) : IDX_W'(tx_cnt_q - CNT_W'(1));
    rx_idx_c    = lsb_q ? IDX_W'(rx_cnt_q) : IDX_W'(n_q - CNT_W'(1) - rx_cnt_q);
    rx_final_c  = (rx_cnt_q == n_q - CNT_W'(1));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    lsb_d     = lsb_q;
    tx_neg_d  = tx_neg_q;
    rx_neg_d  = rx_neg_q;
    shadow_d  = shadow_q;
    mosi_d    = mosi_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d   = ST_SHIFT;
          n_d       = n_dec_c;
          tx_cnt_d  = n_dec_c - CNT_W'(1);
          rx_cnt_d  = '0;
          lsb_d     = lsb;
          tx_neg_d  = tx_negedge;
          rx_neg_d  = rx_negedge;
          shadow_d  = tx_data;
          mosi_d    = tx_data[first_idx_c];
          rx_data_d = '0;
        end
      end
      ST_SHIFT: begin
        if (tx_edge_c && (tx_cnt_q != '0)) begin
          mosi_d   = shadow_q[tx_idx_c];
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
        // A coincident launch does not affect the bit captured here.
        // miso is taken as it is in this cycle.
        if (rx_edge_c) begin
          rx_data_d[rx_idx_c] = miso;
          rx_cnt_d            = rx_cnt_q + CNT_W'(1);
          if (rx_final_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      lsb_q     <= 1'b0;
      tx_neg_q  <= 1'b0;
      rx_neg_q  <= 1'b0;
      shadow_q  <= '0;
      mosi_q    <= 1'b0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      lsb_q     <= lsb_d;
      tx_neg_q  <= tx_neg_d;
      rx_neg_q  <= rx_neg_d;
      shadow_q  <= shadow_d;
      mosi_q    <= mosi_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
    end
  end

  assign tip     = (state_q == ST_SHIFT);
  assign last    = tip && (tx_cnt_q == '0);
  assign mosi    = mosi_q;
  assign rx_data = rx_data_q;
  assign done    = done_q;

endmodule
